// File: rtl/ihex_tx.sv
// ihex_tx: Intel HEX record encoder feeding a UART transmitter.
// Data bytes are buffered (up to MAX_LEN) and then sent as a single record
// ":LLAAAATT<DD..>CC" followed by a line end, one ASCII char per strobe.
// Optional build macro IHEX_TX_CRLF_EN: line end is CR LF instead of LF only.
//
// UART handshake: a char is offered only when i_tx_busy is low in ISSUE;
// o_tx_stb is then high for exactly one cycle with o_tx_data valid in that
// same cycle, and the following GAP cycle ignores i_tx_busy so the UART has
// time to raise it before the next char is considered.
module ihex_tx #(
    parameter int MAX_LEN = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wr_stb,
    input  logic [7:0]  i_wr_data,
    input  logic        i_start,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_type,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_stb,
    input  logic        i_tx_busy,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overflow,
    output logic [1:0]  o_state
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int FW = $clog2(MAX_LEN + 1);
    localparam int IW = 10;
`ifdef IHEX_TX_CRLF_EN
    localparam int LE_LEN = 2;
`else
    localparam int LE_LEN = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      buf_q [2**AW];
    logic [FW-1:0]   fill_q, fill_d;
    logic            ovf_q;
    logic [15:0]     addr_q;
    logic [7:0]      type_q;
    logic [7:0]      sum_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      tx_data_q;
    logic            tx_stb_q;

    logic            idle;
    logic            wr_acc;
    logic            wr_drop;
    logic            start_acc;
    logic            fire;
    logic [7:0]      ll;
    logic [7:0]      seed;
    logic [7:0]      cks;
    logic [IW-1:0]   n_chars;
    logic [IW-1:0]   data_end;
    logic [AW:0]     d_off;
    logic [7:0]      data_byte;
    logic [3:0]      nib;
    logic            use_lit;
    logic [7:0]      lit;
    logic            data_lo;
    logic [7:0]      char_out;

    // Request qualification and record geometry derived from the buffer fill.
    assign idle      = (state_q == S_IDLE);
    assign wr_acc    = idle && i_wr_stb && (fill_q != FW'(MAX_LEN));
    assign wr_drop   = idle && i_wr_stb && (fill_q == FW'(MAX_LEN));
    assign start_acc = idle && i_start;
    assign ll        = 8'(fill_q);
    assign cks       = 8'h00 - sum_q;
    assign data_end  = 10'd9 + {1'b0, ll, 1'b0};
    assign n_chars   = data_end + IW'(2 + LE_LEN);
    assign d_off     = (AW+1)'(idx_q - 10'd9);
    assign data_byte = buf_q[d_off[AW:1]];

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic: issue a char, wait one gap cycle, repeat until the line end is out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_acc) state_d = S_ISSUE;
            S_ISSUE:  if (!i_tx_busy) state_d = S_GAP;
            S_GAP:    state_d = (idx_q == n_chars) ? S_FINISH : S_ISSUE;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        fire    = (state_q == S_ISSUE) && !i_tx_busy;
        o_busy  = (state_q != S_IDLE);
        o_done  = (state_q == S_FINISH);
        o_state = state_q;
    end

    // Character selection for the current index: ':' then hex fields then line end.
    always_comb begin
        nib     = 4'h0;
        use_lit = 1'b0;
        lit     = 8'h0A;
        data_lo = 1'b0;
        if (idx_q == 10'd0) begin
            use_lit = 1'b1;
            lit     = 8'h3A;
        end else if (idx_q == 10'd1) nib = ll[7:4];
        else if (idx_q == 10'd2) nib = ll[3:0];
        else if (idx_q == 10'd3) nib = addr_q[15:12];
        else if (idx_q == 10'd4) nib = addr_q[11:8];
        else if (idx_q == 10'd5) nib = addr_q[7:4];
        else if (idx_q == 10'd6) nib = addr_q[3:0];
        else if (idx_q == 10'd7) nib = type_q[7:4];
        else if (idx_q == 10'd8) nib = type_q[3:0];
        else if (idx_q < data_end) begin
            nib     = d_off[0] ? data_byte[3:0] : data_byte[7:4];
            data_lo = d_off[0];
        end else if (idx_q == data_end) nib = cks[7:4];
        else if (idx_q == data_end + 10'd1) nib = cks[3:0];
        else begin
            use_lit = 1'b1;
`ifdef IHEX_TX_CRLF_EN
            lit = (idx_q == data_end + 10'd2) ? 8'h0D : 8'h0A;
`else
            lit = 8'h0A;
`endif
        end
        if (use_lit)          char_out = lit;
        else if (nib < 4'd10) char_out = {4'h3, nib};
        else                  char_out = 8'h37 + {4'h0, nib};
    end

    // Fill count: grows on accepted writes, cleared when a record completes.
    always_comb begin
        fill_d = fill_q;
        if (wr_acc)              fill_d = fill_q + FW'(1);
        if (state_q == S_FINISH) fill_d = '0;
        seed = ll + i_addr[15:8] + i_addr[7:0] + i_type;
        if (wr_acc) seed = seed + 8'd1;
    end

    // Data buffer: no reset needed, contents are only read below the fill count.
    always_ff @(posedge i_clk) begin
        if (wr_acc) buf_q[fill_q[AW-1:0]] <= i_wr_data;
    end

    // Record datapath: header latch, char index, running checksum, UART outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill_q    <= '0;
            ovf_q     <= 1'b0;
            addr_q    <= 16'h0000;
            type_q    <= 8'h00;
            sum_q     <= 8'h00;
            idx_q     <= '0;
            tx_data_q <= 8'h00;
            tx_stb_q  <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            tx_stb_q <= fire;
            if (wr_drop)             ovf_q <= 1'b1;
            if (state_q == S_FINISH) ovf_q <= 1'b0;
            if (start_acc) begin
                addr_q <= i_addr;
                type_q <= i_type;
                sum_q  <= seed;
                idx_q  <= '0;
            end
            if (fire) begin
                tx_data_q <= char_out;
                idx_q     <= idx_q + 10'd1;
                if (data_lo) sum_q <= sum_q + data_byte;
            end
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_stb   = tx_stb_q;
    assign o_overflow = ovf_q;

endmodule
